// File: rtl/i2c_wb_arbiter.sv
// Two-requester Wishbone arbiter in front of the I2C master register port.
// Round-robin grant locked for a whole cyc tenure, with a stalled-strobe timeout.
module i2c_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned AW             = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,

  output logic [1:0]    grant_o,
  output logic          timeout_irq_o,
  input  logic          timeout_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;

  logic own0, own1, owner_stb, timeout;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_d;
    end
  end

  // A contest goes to whoever was not served last; ownership only ends through IDLE.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_owner_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign own0      = (state_q == OWN0);
  assign own1      = (state_q == OWN1);
  assign owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  // An ack landing on the limit cycle wins over the timeout.
  assign timeout   = owner_stb & ~s_ack_i & (cnt_q == TIMEOUT_LIM);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
    s_stb_o = owner_stb & ~timeout;
  end

  always_comb begin
    m0_ack_o = own0 & s_ack_i;
    m0_err_o = own0 & timeout;
    m0_dat_o = own0 ? s_dat_i : 32'd0;
    m1_ack_o = own1 & s_ack_i;
    m1_err_o = own1 & timeout;
    m1_dat_o = own1 ? s_dat_i : 32'd0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) || (state_d != state_q) || s_ack_i || timeout) begin
      cnt_d = '0;
    end else if (s_stb_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    irq_d = irq_q;
    if (timeout)            irq_d = 1'b1;
    else if (timeout_clr_i) irq_d = 1'b0;
  end

  assign grant_o       = {own1, own0};
  assign timeout_irq_o = irq_q;

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Scoreboard bench for i2c_wb_arbiter: drivers push expected responses and grants,
// independent monitors pop and compare them as the DUT produces them.
module tb_i2c_wb_arbiter;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat, s_dat_in;
  logic        s_ack_in;
  logic [1:0]  grant;
  logic        irq;

  i2c_wb_arbiter #(.TIMEOUT_CYCLES(T), .AW(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_dat), .s_dat_i(s_dat_in), .s_ack_i(s_ack_in),
    .grant_o(grant), .timeout_irq_o(irq), .timeout_clr_i(clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          lat;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] rdat;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    int          age;
  } exp_t;

  beat_t bq0[$], bq1[$];
  exp_t  eq0[$], eq1[$];
  int    grant_exp[$];

  int          tests = 0;
  int          fails = 0;
  int          cyc_cnt = 0;
  int          grant_cycle = 0;
  int          req_cycle [2];
  int          drop_cycle [2];
  int          lat_cfg [2];
  logic [31:0] rdata_cfg [2];
  int          model_last = 1;
  bit          model_irq = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: a contest goes to the requester not served last.
  function automatic int winner();
    return (model_last == 1) ? 0 : 1;
  endfunction

  task automatic push_beat(input int n, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input int lat);
    beat_t b;
    b.we = we; b.adr = adr; b.dat = dat; b.sel = sel; b.lat = lat;
    if (lat > T) model_irq = 1'b1;
    if (n == 0) bq0.push_back(b); else bq1.push_back(b);
  endtask

  task automatic fill_random(input int n);
    int nb;
    nb = int'($urandom_range(1, 3));
    for (int i = 0; i < nb; i++)
      push_beat(n, 1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 6)));
  endtask

  // Slave stub: acks once a beat has been stalled for lat_cfg cycles of the owner.
  int slave_cnt = 0;
  initial begin
    int  own;
    bit  seen;
    s_ack_in = 1'b0;
    s_dat_in = '0;
    forever begin
      @(posedge clk);
      #2;
      own  = grant[1] ? 1 : 0;
      seen = s_cyc && ((grant[0] && m_stb[0]) || (grant[1] && m_stb[1]));
      s_ack_in = seen && (slave_cnt == lat_cfg[own]);
      s_dat_in = s_ack_in ? rdata_cfg[own] : $urandom;
      @(negedge clk);
      if (seen && !s_ack_in && !m0_err && !m1_err) slave_cnt++;
      else slave_cnt = 0;
    end
  end

  task automatic session(input int n);
    beat_t b;
    exp_t  e;
    int    guard;
    int    left;
    @(posedge clk);
    #1;
    req_cycle[n] = cyc_cnt;
    m_cyc[n] = 1'b1;
    left = (n == 0) ? bq0.size() : bq1.size();
    while (left > 0) begin
      if (n == 0) b = bq0.pop_front(); else b = bq1.pop_front();
      m_stb[n] = 1'b1; m_we[n] = b.we; m_adr[n] = b.adr; m_dat[n] = b.dat; m_sel[n] = b.sel;
      lat_cfg[n] = b.lat;
      rdata_cfg[n] = $urandom;
      e.err = (b.lat > T); e.rdat = rdata_cfg[n]; e.adr = b.adr; e.wdat = b.dat;
      e.we = b.we; e.sel = b.sel; e.age = (b.lat > T) ? T : b.lat;
      if (n == 0) eq0.push_back(e); else eq1.push_back(e);
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!((n == 0) ? (m0_ack || m0_err) : (m1_ack || m1_err)) && guard < 200);
      if (guard >= 200) check("response_wait_bound", 0, 1);
      @(posedge clk);
      #1;
      left = (n == 0) ? bq0.size() : bq1.size();
    end
    m_stb[n] = 1'b0;
    m_cyc[n] = 1'b0;
    drop_cycle[n] = cyc_cnt;
    model_last = n;
  endtask

  task automatic respond(input int n, input logic ack, input logic err);
    exp_t e;
    int   sz;
    sz = (n == 0) ? eq0.size() : eq1.size();
    check("response_expected", 64'(sz > 0), 1);
    if (sz == 0) return;
    if (n == 0) e = eq0.pop_front(); else e = eq1.pop_front();
    check("resp_err", err, e.err);
    check("resp_ack", ack, !e.err);
    if (ack) check("resp_rdata", (n == 0) ? m0_dat_o : m1_dat_o, e.rdat);
    check("resp_age", age[n], e.age);
    check("s_adr", s_adr, e.adr);
    check("s_dat", s_dat, e.wdat);
    check("s_we", s_we, e.we);
    check("s_sel", s_sel, e.sel);
    check("s_stb_at_resp", s_stb, !e.err);
    check("grant_at_resp", grant, (n == 0) ? 2'b01 : 2'b10);
    check("other_ack_err", (n == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err), 0);
    check("other_dat", (n == 0) ? m1_dat_o : m0_dat_o, 0);
  endtask

  int age [2];
  initial begin
    logic a, r;
    age[0] = 0; age[1] = 0;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        a = (n == 0) ? m0_ack : m1_ack;
        r = (n == 0) ? m0_err : m1_err;
        if (a || r) begin
          respond(n, a, r);
          age[n] = 0;
        end else if (m_stb[n] && grant[n]) age[n]++;
        else age[n] = 0;
      end
    end
  end

  initial begin
    logic [1:0] prev;
    int         g;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (grant !== prev) begin
        if (grant == 2'b00) begin
          check("idle_s_cyc", s_cyc, 0);
          check("idle_s_adr", s_adr, 0);
          check("idle_s_dat", s_dat, 0);
        end else if (prev == 2'b00) begin
          if (grant_exp.size() == 0) check("grant_unexpected", grant, 0);
          else begin
            g = grant_exp.pop_front();
            check("grant_owner", grant, (g == 0) ? 2'b01 : 2'b10);
          end
          grant_cycle = cyc_cnt;
        end else begin
          check("grant_direct_handoff", prev, 0);
        end
        prev = grant;
      end
    end
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got no completion, expected finish within budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode, w;
    rst = 1'b1; clr = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = '0; m_adr[i] = '0; m_dat[i] = '0;
      lat_cfg[i] = 0; rdata_cfg[i] = '0; req_cycle[i] = 0; drop_cycle[i] = 0;
    end

    @(posedge clk);
    #1;
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_stb", s_stb, 0);
    check("rst_s_we", s_we, 0);
    check("rst_s_sel", s_sel, 0);
    check("rst_s_adr", s_adr, 0);
    check("rst_s_dat", s_dat, 0);
    check("rst_grant", grant, 0);
    check("rst_irq", irq, 0);
    check("rst_m0", {m0_ack, m0_err, m0_dat_o}, 0);
    check("rst_m1", {m1_ack, m1_err, m1_dat_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contest right after reset, then again after both finish.
    for (int k = 0; k < 2; k++) begin
      push_beat(0, 1'b1, 32'h20 + k, $urandom, 4'hF, int'($urandom_range(0, 2)));
      push_beat(1, 1'b0, 32'h40 + k, $urandom, 4'h3, int'($urandom_range(0, 2)));
      w = winner();
      grant_exp.push_back(w);
      grant_exp.push_back(1 - w);
      fork
        session(0);
        session(1);
      join
    end

    // Single write, ack on the second strobe cycle.
    push_beat(0, 1'b1, 32'h08, 32'hA5, 4'hF, 1);
    grant_exp.push_back(0);
    session(0);
    check("grant_latency", grant_cycle - req_cycle[0], 1);

    // Lock: m1 3-beat burst, m0 requests mid-burst.
    for (int i = 0; i < 3; i++) push_beat(1, 1'b0, 32'h100 + i, $urandom, 4'hF, 1);
    push_beat(0, 1'b1, 32'h200, $urandom, 4'hF, 0);
    grant_exp.push_back(1);
    grant_exp.push_back(0);
    fork
      session(1);
      begin
        repeat (3) @(posedge clk);
        session(0);
      end
    join
    check("handoff_latency", grant_cycle - drop_cycle[1], 2);

    // Timeout, sticky irq, clear, ack on the limit cycle, set beating clear.
    push_beat(0, 1'b0, 32'h0C, 32'h0, 4'hF, 10);
    grant_exp.push_back(0);
    session(0);
    check("irq_set", irq, 1);
    @(posedge clk);
    #1;
    check("irq_sticky", irq, 1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("irq_clr", irq, 0);
    push_beat(0, 1'b0, 32'h0C, 32'h0, 4'hF, T);
    grant_exp.push_back(0);
    session(0);
    check("irq_ack_at_limit", irq, 0);
    clr = 1'b1;
    push_beat(0, 1'b1, 32'h0D, 32'h1, 4'hF, 9);
    grant_exp.push_back(0);
    session(0);
    check("irq_set_wins", irq, 1);
    @(posedge clk);
    #1;
    check("irq_clr_after_set", irq, 0);
    clr = 1'b0;

    // Async reset while m1 owns, in the cycle its read is being acked.
    grant_exp.push_back(1);
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h10;
    lat_cfg[1] = 2; rdata_cfg[1] = 32'h5A5A_0001;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_m1_ack", m1_ack, 1);
    check("pre_rst_grant", grant, 2'b10);
    rst = 1'b1;
    #1;
    check("arst_s_cyc", s_cyc, 0);
    check("arst_s_stb", s_stb, 0);
    check("arst_grant", grant, 0);
    check("arst_m1", {m1_ack, m1_err, m1_dat_o}, 0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    model_last = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_beat(0, 1'b0, 32'h30, $urandom, 4'hF, 1);
    push_beat(1, 1'b0, 32'h34, $urandom, 4'hF, 1);
    w = winner();
    grant_exp.push_back(w);
    grant_exp.push_back(1 - w);
    fork
      session(0);
      session(1);
    join

    // Randomized sessions.
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_irq = 1'b0;
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      if (mode != 1) fill_random(0);
      if (mode != 0) fill_random(1);
      if (mode == 2) begin
        w = winner();
        grant_exp.push_back(w);
        grant_exp.push_back(1 - w);
        fork
          session(0);
          session(1);
        join
      end else begin
        grant_exp.push_back(mode);
        session(mode);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("random_irq", irq, model_irq);

    repeat (4) @(posedge clk);
    check("eq0_drained", eq0.size(), 0);
    check("eq1_drained", eq1.size(), 0);
    check("grant_exp_drained", grant_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
